// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller for load-use stalls, CSR serialisation
//            and redirect flushes, with a stall-cycle counter.
// Revision : 1.0
// ============================================================================

module hazard_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic        i_id_is_csr,
  input  logic        i_ex_valid,
  input  logic        i_mem_valid,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_wb_is_csr,
  input  logic        i_redirect,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_bubble_ex,
  output logic        o_flush_id,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    DRAIN       = 2'd1,
    WAIT_RETIRE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_stall_cycles;
  logic        w_lu;
  logic        w_busy;
  logic        w_csrid;
  logic        w_stall;
  logic        w_bubble;
  logic        w_flush;

  assign w_lu = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) &
                ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                 (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
  assign w_busy  = i_ex_valid | i_mem_valid | i_wb_valid;
  assign w_csrid = i_id_valid & i_id_is_csr;

  always_comb begin
    w_next   = RUN;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (i_redirect) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      case (r_state)
        DRAIN: begin
          if (w_busy) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            w_next   = DRAIN;
          end else begin
            w_next   = WAIT_RETIRE;
          end
        end
        WAIT_RETIRE: begin
          if (!(i_wb_valid & i_wb_is_csr)) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            w_next   = WAIT_RETIRE;
          end
        end
        // RUN and the unused encoding share the same behaviour
        default: begin
          if (w_csrid & w_busy) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            w_next   = DRAIN;
          end else if (w_csrid) begin
            w_next   = WAIT_RETIRE;
          end else if (w_lu) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= RUN;
      r_stall_cycles <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // Controls are masked while reset is held so the pipeline sees no action
  assign o_stall_id     = w_stall & i_rst_n;
  assign o_stall_if     = w_stall & i_rst_n;
  assign o_bubble_ex    = w_bubble & i_rst_n;
  assign o_flush_id     = w_flush & i_rst_n;
  assign o_state        = r_state;
  assign o_stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl stall/bubble/flush sequencing.
// Revision : 1.0
// ============================================================================

module tb_hazard_ctrl;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       csr;
    logic       exv;
    logic       memv;
    logic       wbv;
    logic [4:0] exrd;
    logic       exld;
    logic       wbcsr;
    logic       redir;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  state;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic        id_is_csr = 1'b0;
  logic        ex_valid = 1'b0;
  logic        mem_valid = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_mem_read = 1'b0;
  logic        wb_is_csr = 1'b0;
  logic        redirect = 1'b0;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_id;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  exp_t        sb_q[$];
  logic [31:0] exp_cnt = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  hazard_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_id_is_csr   (id_is_csr),
    .i_ex_valid    (ex_valid),
    .i_mem_valid   (mem_valid),
    .i_wb_valid    (wb_valid),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .i_wb_is_csr   (wb_is_csr),
    .i_redirect    (redirect),
    .o_stall_if    (stall_if),
    .o_stall_id    (stall_id),
    .o_bubble_ex   (bubble_ex),
    .o_flush_id    (flush_id),
    .o_state       (state),
    .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic csr,
                               input logic exv, input logic memv, input logic wbv,
                               input logic [4:0] exrd, input logic exld,
                               input logic wbcsr, input logic redir);
    stim_t s;
    s.id_valid = idv; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.csr = csr;
    s.exv = exv; s.memv = memv; s.wbv = wbv; s.exrd = exrd; s.exld = exld;
    s.wbcsr = wbcsr; s.redir = redir;
    return s;
  endfunction

  // Apply one cycle of stimulus mid-low phase and queue its expected outputs
  task automatic drive(input stim_t s, input logic [4:0] exp_ctl);
    exp_t e;
    @(negedge clk);
    id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_is_csr = s.csr;
    ex_valid = s.exv; mem_valid = s.memv; wb_valid = s.wbv;
    ex_rd = s.exrd; ex_mem_read = s.exld; wb_is_csr = s.wbcsr; redirect = s.redir;
    e.stall = exp_ctl[4]; e.bubble = exp_ctl[3]; e.flush = exp_ctl[2];
    e.state = exp_ctl[1:0]; e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (exp_ctl[4] && rst_n) exp_cnt = exp_cnt + 32'd1;
    #2;
  endtask

  task automatic test_reset();
    stim_t       s[2];
    logic [4:0]  x[2];
    exp_t        e;
    s[0] = mk(1, 5'd5, 5'd0, 1, 0, 0, 1, 0, 0, 5'd5, 1, 0, 0); x[0] = 5'b000_00;
    s[1] = mk(1, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 5'd0, 0, 0, 1); x[1] = 5'b000_00;
    for (int i = 0; i < 2; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t       s[5];
    logic [4:0]  x[5];
    exp_t        e;
    s[0] = mk(1, 5'd0, 5'd5, 0, 1, 0, 1, 0, 0, 5'd5, 1, 0, 0); x[0] = 5'b110_00;
    s[1] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[1] = 5'b000_00;
    s[2] = mk(1, 5'd7, 5'd0, 1, 0, 0, 1, 0, 0, 5'd7, 1, 0, 0); x[2] = 5'b110_00;
    s[3] = mk(0, 5'd7, 5'd0, 1, 0, 0, 1, 0, 0, 5'd7, 1, 0, 0); x[3] = 5'b000_00;
    s[4] = mk(1, 5'd7, 5'd0, 1, 0, 0, 0, 1, 0, 5'd7, 1, 0, 0); x[4] = 5'b000_00;
    for (int i = 0; i < 5; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  task automatic test_no_hazard();
    stim_t       s[4];
    logic [4:0]  x[4];
    exp_t        e;
    s[0] = mk(1, 5'd0, 5'd3, 1, 0, 0, 1, 0, 0, 5'd0, 1, 0, 0); x[0] = 5'b000_00;
    s[1] = mk(1, 5'd5, 5'd0, 1, 0, 0, 1, 0, 0, 5'd5, 0, 0, 0); x[1] = 5'b000_00;
    s[2] = mk(1, 5'd3, 5'd5, 1, 0, 0, 1, 0, 0, 5'd5, 1, 0, 0); x[2] = 5'b000_00;
    s[3] = mk(1, 5'd5, 5'd5, 0, 0, 0, 1, 0, 0, 5'd5, 1, 0, 0); x[3] = 5'b000_00;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL no_hazard[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  task automatic test_csr_drain();
    stim_t       s[8];
    logic [4:0]  x[8];
    exp_t        e;
    s[0] = mk(1, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 5'd0, 0, 0, 0); x[0] = 5'b110_00;
    s[1] = mk(1, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 5'd0, 0, 0, 0); x[1] = 5'b110_01;
    s[2] = mk(1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0); x[2] = 5'b000_01;
    s[3] = mk(0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 0); x[3] = 5'b110_10;
    s[4] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0); x[4] = 5'b110_10;
    s[5] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0); x[5] = 5'b110_10;
    s[6] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 1, 0); x[6] = 5'b000_10;
    s[7] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[7] = 5'b000_00;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL csr_drain[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t       s[8];
    logic [4:0]  x[8];
    exp_t        e;
    s[0] = mk(1, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, 0, 0); x[0] = 5'b110_00;
    s[1] = mk(1, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, 0, 1); x[1] = 5'b011_01;
    s[2] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[2] = 5'b000_00;
    s[3] = mk(1, 5'd9, 5'd0, 1, 0, 0, 1, 0, 0, 5'd9, 1, 0, 1); x[3] = 5'b011_00;
    s[4] = mk(1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0); x[4] = 5'b000_00;
    s[5] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[5] = 5'b110_10;
    s[6] = mk(0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 1); x[6] = 5'b011_10;
    s[7] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[7] = 5'b000_00;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL redirect[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    stim_t       s[2];
    logic [4:0]  x[2];
    exp_t        e;
    @(negedge clk);
    force dut.r_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cycles;
    exp_cnt = 32'hFFFF_FFFF;
    s[0] = mk(1, 5'd0, 5'd4, 0, 1, 0, 1, 0, 0, 5'd4, 1, 0, 0); x[0] = 5'b110_00;
    s[1] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[1] = 5'b000_00;
    for (int i = 0; i < 2; i++) begin
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL counter_wrap[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t       s[3];
    logic [4:0]  x[3];
    exp_t        e;
    s[0] = mk(1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 0, 0); x[0] = 5'b000_00;
    s[1] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[1] = 5'b110_10;
    s[2] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0); x[2] = 5'b000_00;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        // Drop reset between edges while the FSM still waits for retirement
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        e.stall = 1'b0; e.bubble = 1'b0; e.flush = 1'b0; e.state = 2'd0; e.cnt = 32'd0;
        sb_q.push_back(e);
        e = sb_q.pop_front();
        vectors++;
        if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
            {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
          miscompares++;
          $display("FAIL async_reset_mid: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp all zero",
                   stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive(s[i], x[i]);
      e = sb_q.pop_front();
      vectors++;
      if ({stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles} !==
          {e.stall, e.stall, e.bubble, e.flush, e.state, e.cnt}) begin
        miscompares++;
        $display("FAIL async_reset[%0d]: got if=%b id=%b bub=%b fl=%b st=%0d cnt=%h exp stall=%b bub=%b fl=%b st=%0d cnt=%h",
                 i, stall_if, stall_id, bubble_ex, flush_id, state, stall_cycles,
                 e.stall, e.bubble, e.flush, e.state, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_csr_drain();
    test_redirect();
    test_counter_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
